fetch_queue: RTL and testbench

Instruction prefetch queue between the F stage (PC, IM, PC adder) and the D-stage pipeline register.
- Buffers fetched {instruction, PC+1} pairs so fetch can keep running while decode stalls.
- Discards all buffered entries on a branch or jump redirect.
- Uses valid/ready handshakes on both sides and replaces the simple EN/CLR gating of the F-to-D boundary.

---
 rtl/fq_pkg.sv | 19 +
 rtl/fq_storage.sv | 32 +++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// fq_pkg: shared types and helpers for the instruction fetch queue.
//   NOP_INSTR  - instruction presented to decode when the queue has nothing valid
//   fq_entry_t - one buffered {instr, pcp1} pair (32-bit datapath)
//   fq_ptr_w   - pointer width for a given queue depth
package fq_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcp1;
   } fq_entry_t;

   // A depth of 1 would give a zero-width pointer; clamp to one bit.
   function automatic int fq_ptr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH x WW register array for the fetch queue.
//   clk     - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address (asynchronous read)
//   o_rdata - read data
// Contents are not reset; control logic guarantees nothing stale is read.
module fq_storage
   import fq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WW    = 64,
   parameter int AW    = fq_ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [WW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [WW-1:0] o_rdata
);

   logic [WW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between fetch and the decode register.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - fetch-side handshake
//   in_instr, in_pcp1    - fetched instruction and its PC+1
//   out_valid/out_ready  - decode-side handshake (out_ready low on decode stall)
//   out_instr, out_pcp1  - head entry; NOP/0 whenever out_valid is low
//   flush                - redirect: discard everything, ignore this cycle's push/pop
//   count                - current occupancy
// Build option FQ_BYPASS_EN: when empty, forward in_* straight to out_*
// (zero-cycle latency). Default leaves the fetch-to-decode path registered.
module fetch_queue
   import fq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DW-1:0]              in_instr,
   input  logic [DW-1:0]              in_pcp1,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DW-1:0]              out_instr,
   output logic [DW-1:0]              out_pcp1,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = fq_ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [2*DW-1:0] w_head;
   logic            w_empty, w_full, w_byp;
   logic            w_push, w_pop, w_we;
   logic [DW-1:0]   w_instr, w_pcp1;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

`ifdef FQ_BYPASS_EN
   assign w_byp = w_empty && in_valid && !flush;
`else
   assign w_byp = 1'b0;
`endif

   // Flush squashes the head combinationally so decode sees a NOP this cycle.
   assign out_valid = (!w_empty || w_byp) && !flush;
   assign in_ready  = !w_full || (out_ready && out_valid);

   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = out_valid && out_ready;
   // A bypassed word that decode takes immediately never enters storage.
   assign w_we   = w_push && !(w_byp && out_ready);

   assign w_instr   = w_byp ? in_instr : w_head[2*DW-1:DW];
   assign w_pcp1    = w_byp ? in_pcp1  : w_head[DW-1:0];
   assign out_instr = out_valid ? w_instr : DW'(NOP_INSTR);
   assign out_pcp1  = out_valid ? w_pcp1  : '0;
   assign count     = r_count;

   fq_storage #(.DEPTH(DEPTH), .WW(2*DW), .AW(AW)) u_storage (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata ({in_instr, in_pcp1}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // A bypassed-and-consumed word moves neither pointer nor count.
         if (w_we)               r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
         if (w_pop && !w_byp)    r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
         if (w_we && !(w_pop && !w_byp))      r_count <= r_count + 1'b1;
         else if (!w_we && w_pop && !w_byp)   r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   import fq_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_instr = '0;
   logic [DW-1:0] in_pcp1 = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_instr;
   logic [DW-1:0] out_pcp1;
   logic          flush = 1'b0;
   logic [2:0]    count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pcp1(in_pcp1),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pcp1(out_pcp1),
      .flush(flush), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
      in_valid = v; in_instr = ins; in_pcp1 = p;
   endtask

   fq_entry_t e;

   initial begin
      // reset state
      #12;
      chk("rst_count", count, 0);
      chk("rst_ovld", out_valid, 0);
      chk("rst_oinstr", out_instr, 0);
      chk("rst_opcp1", out_pcp1, 0);
      chk("rst_irdy", in_ready, 1);
      rst_n = 1'b1;
      tick();

      // 1: single push, one-cycle latency
      drive(1, 32'h2008_0005, 1);
      out_ready = 0;
`ifndef FQ_BYPASS_EN
      #1 chk("t1_no_bypass", out_valid, 0);
`endif
      tick();
      drive(0, 0, 0);
      #1;
      chk("t1_ovld", out_valid, 1);
      chk("t1_instr", out_instr, 32'h2008_0005);
      chk("t1_pcp1", out_pcp1, 1);
      chk("t1_count", count, 1);

      // clear via flush
      flush = 1; tick(); flush = 0;

      // 2: fill, full refusal, push+pop while full
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h100 + i, 11 + i); tick();
      end
      #1;
      chk("t2_count_full", count, 4);
      chk("t2_irdy_full", in_ready, 0);
      drive(1, 32'h104, 15);
      tick();
      chk("t2_count_hold", count, 4);
      chk("t2_head_hold", out_pcp1, 11);
      out_ready = 1;
      #1 chk("t2_irdy_pop", in_ready, 1);
      tick();
      drive(0, 0, 0);
      #1;
      chk("t2_count_pp", count, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain", out_pcp1, 12 + i);
         tick();
      end
      chk("t2_empty", count, 0);

      // 3: 10 sequential words, out_ready toggling, wraps twice
      begin
         int k = 1, expp = 1, cyc = 0;
         while (expp <= 10 && cyc < 100) begin
            out_ready = (cyc % 2 == 0);
            if (k <= 10) drive(1, 32'h1000_0000 + k, k);
            else drive(0, 0, 0);
            #1;
            if (out_valid && out_ready) begin
               chk("t3_pcp1", out_pcp1, expp);
               chk("t3_instr", out_instr, 32'h1000_0000 + expp);
               expp++;
            end
            if (in_valid && in_ready) k++;
            tick();
            cyc++;
         end
         chk("t3_done", expp, 11);
         drive(0, 0, 0);
         out_ready = 0;
         #1 chk("t3_count", count, 0);
      end

      // 4: flush with concurrent push and pop
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h200 + i, 21 + i); tick();
      end
      chk("t4_count3", count, 3);
      drive(1, 32'h299, 99);
      out_ready = 1; flush = 1;
      #1;
      chk("t4_ovld", out_valid, 0);
      chk("t4_oinstr", out_instr, 0);
      tick();
      flush = 0; drive(0, 0, 0); out_ready = 0;
      #1;
      chk("t4_count", count, 0);
      chk("t4_ovld_next", out_valid, 0);
      drive(1, 32'h300, 31); tick(); drive(0, 0, 0);
      #1;
      chk("t4_after_cnt", count, 1);
      chk("t4_after_head", out_pcp1, 31);
      flush = 1; tick(); flush = 0;

      // 5: asynchronous reset mid-cycle
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h400 + i, 41 + i); tick();
      end
      drive(0, 0, 0);
      chk("t5_count2", count, 2);
      #1 rst_n = 0;
      #1;
      chk("t5_count", count, 0);
      chk("t5_ovld", out_valid, 0);
      chk("t5_oinstr", out_instr, 0);
      @(negedge clk); rst_n = 1;
      tick();

`ifdef FQ_BYPASS_EN
      // 6: bypass when empty
      drive(1, 32'h8C09_0004, 7);
      out_ready = 1;
      #1;
      chk("t6_ovld", out_valid, 1);
      chk("t6_instr", out_instr, 32'h8C09_0004);
      tick();
      drive(0, 0, 0);
      #1;
      chk("t6_count", count, 0);
      chk("t6_ovld_next", out_valid, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
